// File: rtl/matmul_job_sequencer.sv
// Job-level sequencer for the systolic matmul engine: validates one C=AxB job, holds engine sizes,
// tracks tiles and emits per-tile commits and a done pulse. Optional cycle counter: MATMUL_SEQ_PERF_EN.
module matmul_job_sequencer #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W_C     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [MATRIXSIZE_W-1:0] cfg_m1,
    input  logic [MATRIXSIZE_W-1:0] cfg_m2,
    input  logic [MATRIXSIZE_W-1:0] cfg_m3,
    input  logic [ADDR_W_C-1:0]     cfg_base_c,
    input  logic                    abort,
    output logic                    eng_rst,
    output logic [MATRIXSIZE_W-1:0] eng_m2,
    output logic [MATRIXSIZE_W-1:0] eng_m1dn1,
    output logic [MATRIXSIZE_W-1:0] eng_m3dn2,
    output logic [MATRIXSIZE_W-1:0] eng_m1xm3dn1xn2,
    input  logic                    tile_start,
    output logic                    tile_commit,
    output logic [MATRIXSIZE_W-1:0] tile_row,
    output logic [MATRIXSIZE_W-1:0] tile_col,
    output logic [ADDR_W_C-1:0]     tile_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    job_err,
    output logic                    aborted,
    output logic [31:0]             perf_cycles
);
    localparam int W     = MATRIXSIZE_W;
    localparam int LG_N1 = $clog2(N1);
    localparam int LG_N2 = $clog2(N2);
    localparam int FL_W  = MATRIXSIZE_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;
    state_t state_q, state_d;

    logic [W-1:0]        eng_m2_q, eng_m2_d, eng_m1dn1_q, eng_m1dn1_d;
    logic [W-1:0]        eng_m3dn2_q, eng_m3dn2_d, eng_cnt_q, eng_cnt_d;
    logic [ADDR_W_C-1:0] base_q, base_d;
    logic [W-1:0]        seen_q, seen_d;
    logic [FL_W-1:0]     fl_q, fl_d;
    logic [W-1:0]        cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [ADDR_W_C-1:0] cur_addr_q, cur_addr_d;
    logic [W-1:0]        row_q, row_d, col_q, col_d;
    logic [ADDR_W_C-1:0] addr_q, addr_d;
    logic                commit_q, commit_d, job_err_q, job_err_d, aborted_q, aborted_d;

    logic [W-1:0]    cfg_m1dn1, cfg_m3dn2;
    logic [2*W-1:0]  cfg_prod;
    logic            cfg_legal, accept, reject, abort_now;
    logic            pulse_run, last_pulse, commit_now;
    logic [FL_W-1:0] flush_len;

    // Dimension checks: divisions are shifts, tile count formed at double width
    assign cfg_m1dn1 = cfg_m1 >> LG_N1;
    assign cfg_m3dn2 = cfg_m3 >> LG_N2;
    assign cfg_prod  = {{W{1'b0}}, cfg_m1dn1} * {{W{1'b0}}, cfg_m3dn2};
    assign cfg_legal = (cfg_m1 != '0) && (cfg_m3 != '0) && (cfg_m2 >= W'(2)) &&
                       (cfg_m1[LG_N1-1:0] == '0) && (cfg_m3[LG_N2-1:0] == '0) &&
                       (cfg_prod[2*W-1:W] == '0);

    assign accept     = (state_q == S_IDLE) && cfg_valid && cfg_legal;
    assign reject     = (state_q == S_IDLE) && cfg_valid && !cfg_legal;
    assign abort_now  = abort && ((state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FLUSH));
    assign pulse_run  = (state_q == S_RUN) && tile_start && !abort;
    assign last_pulse = (seen_q + W'(1)) == eng_cnt_q;
    assign commit_now = (pulse_run && (seen_q != '0)) ||
                        ((state_q == S_FLUSH) && !abort && (fl_q == FL_W'(1)));
    // Flush window spans m2+N1+N2 cycles from the last tile_start; the final commit lands at its end
    assign flush_len  = FL_W'(eng_m2_q) + FL_W'(N1 + N2 - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD;
            S_LOAD:  state_d = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)                        state_d = S_IDLE;
                else if (tile_start && last_pulse) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (abort)            state_d = S_IDLE;
                else if (fl_q == '0)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b1;
        eng_rst   = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RUN, S_FLUSH: eng_rst = 1'b0;
            S_DONE:         done    = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        eng_m2_d    = eng_m2_q;
        eng_m1dn1_d = eng_m1dn1_q;
        eng_m3dn2_d = eng_m3dn2_q;
        eng_cnt_d   = eng_cnt_q;
        base_d      = base_q;
        aborted_d   = aborted_q;
        seen_d      = seen_q;
        fl_d        = fl_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        cur_addr_d  = cur_addr_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        commit_d    = commit_now;
        job_err_d   = reject;

        if (accept) begin
            eng_m2_d    = cfg_m2;
            eng_m1dn1_d = cfg_m1dn1;
            eng_m3dn2_d = cfg_m3dn2;
            eng_cnt_d   = cfg_prod[W-1:0];
            base_d      = cfg_base_c;
            aborted_d   = 1'b0;
        end else if (abort_now) begin
            aborted_d = 1'b1;
        end

        if (state_q == S_LOAD) begin
            seen_d     = '0;
            cur_row_d  = '0;
            cur_col_d  = '0;
            cur_addr_d = base_q;
            row_d      = '0;
            col_d      = '0;
            addr_d     = '0;
        end

        if (pulse_run) begin
            seen_d = seen_q + W'(1);
            if (last_pulse) fl_d = flush_len;
        end else if ((state_q == S_FLUSH) && (fl_q != '0)) begin
            fl_d = fl_q - FL_W'(1);
        end

        // Commit publishes the pending tile, then advances column-fastest
        if (commit_now) begin
            row_d      = cur_row_q;
            col_d      = cur_col_q;
            addr_d     = cur_addr_q;
            cur_addr_d = cur_addr_q + ADDR_W_C'(1);
            if (cur_col_q == eng_m3dn2_q - W'(1)) begin
                cur_col_d = '0;
                cur_row_d = cur_row_q + W'(1);
            end else begin
                cur_col_d = cur_col_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_m2_q    <= '0;
            eng_m1dn1_q <= '0;
            eng_m3dn2_q <= '0;
            eng_cnt_q   <= '0;
            base_q      <= '0;
            aborted_q   <= 1'b0;
            seen_q      <= '0;
            fl_q        <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            cur_addr_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            commit_q    <= 1'b0;
            job_err_q   <= 1'b0;
        end else begin
            eng_m2_q    <= eng_m2_d;
            eng_m1dn1_q <= eng_m1dn1_d;
            eng_m3dn2_q <= eng_m3dn2_d;
            eng_cnt_q   <= eng_cnt_d;
            base_q      <= base_d;
            aborted_q   <= aborted_d;
            seen_q      <= seen_d;
            fl_q        <= fl_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            cur_addr_q  <= cur_addr_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            commit_q    <= commit_d;
            job_err_q   <= job_err_d;
        end
    end

    assign eng_m2          = eng_m2_q;
    assign eng_m1dn1       = eng_m1dn1_q;
    assign eng_m3dn2       = eng_m3dn2_q;
    assign eng_m1xm3dn1xn2 = eng_cnt_q;
    assign tile_commit     = commit_q;
    assign tile_row        = row_q;
    assign tile_col        = col_q;
    assign tile_addr       = addr_q;
    assign job_err         = job_err_q;
    assign aborted         = aborted_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_LOAD)
            perf_d = '0;
        else if (((state_q == S_RUN) || (state_q == S_FLUSH)) && (perf_q != '1))
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Self-checking bench for matmul_job_sequencer: directed and randomized jobs against a
// tile-level reference model of expected commit/done/error cycles.
module tb_matmul_job_sequencer;
    localparam int N1 = 4;
    localparam int N2 = 4;
    localparam int W  = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_m1 = '0, cfg_m2 = '0, cfg_m3 = '0;
    logic [AW-1:0] cfg_base_c = '0;
    logic          abort = 1'b0;
    logic          eng_rst;
    logic [W-1:0]  eng_m2, eng_m1dn1, eng_m3dn2, eng_m1xm3dn1xn2;
    logic          tile_start = 1'b0;
    logic          tile_commit;
    logic [W-1:0]  tile_row, tile_col;
    logic [AW-1:0] tile_addr;
    logic          busy, done, job_err, aborted;
    logic [31:0]   perf_cycles;

    always #5 clk = ~clk;

    matmul_job_sequencer #(.N1(N1), .N2(N2), .MATRIXSIZE_W(W), .ADDR_W_C(AW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m1(cfg_m1), .cfg_m2(cfg_m2), .cfg_m3(cfg_m3), .cfg_base_c(cfg_base_c),
        .abort(abort), .eng_rst(eng_rst), .eng_m2(eng_m2), .eng_m1dn1(eng_m1dn1),
        .eng_m3dn2(eng_m3dn2), .eng_m1xm3dn1xn2(eng_m1xm3dn1xn2), .tile_start(tile_start),
        .tile_commit(tile_commit), .tile_row(tile_row), .tile_col(tile_col),
        .tile_addr(tile_addr), .busy(busy), .done(done), .job_err(job_err),
        .aborted(aborted), .perf_cycles(perf_cycles)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_row[int];
    int exp_col[int];
    int exp_addr[int];
    int exp_done[int];
    int exp_err[int];
    int perf_at_done = 0;
    int done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit c;
        @(posedge clk);
        #1;
        cyc++;
        c = exp_row.exists(cyc) ? 1'b1 : 1'b0;
        chk("tile_commit", 32'(tile_commit), 32'(c));
        if (c) begin
            chk("tile_row", 32'(tile_row), 32'(exp_row[cyc]));
            chk("tile_col", 32'(tile_col), 32'(exp_col[cyc]));
            chk("tile_addr", 32'(tile_addr), 32'(exp_addr[cyc]));
        end
        chk("done", 32'(done), 32'(exp_done.exists(cyc) ? 1 : 0));
        chk("job_err", 32'(job_err), 32'(exp_err.exists(cyc) ? 1 : 0));
        if (exp_done.exists(cyc)) begin
            perf_at_done = perf_cycles;
            done_cyc = cyc;
        end
    endtask

    function automatic bit legal(input int m1, input int m2, input int m3);
        if (m1 == 0 || m3 == 0 || m2 < 2) return 1'b0;
        if ((m1 % N1) != 0 || (m3 % N2) != 0) return 1'b0;
        return (longint'(m1 / N1) * longint'(m3 / N2)) < 65536;
    endfunction

    task automatic expect_tile(input int at, input int t, input int cdn, input int base);
        exp_row[at]  = t / cdn;
        exp_col[at]  = t % cdn;
        exp_addr[at] = (base + t) % (1 << AW);
    endtask

    // One job: gaps are idle cycles before each tile_start; abort_k >= 0 aborts after that pulse
    task automatic run_job(input int m1, input int m2, input int m3, input int base,
                           input int gap_lo, input int gap_hi, input int abort_k);
        int rdn, cdn, tiles, flush, a_cyc, p;
        rdn = m1 / N1;
        cdn = m3 / N2;
        tiles = rdn * cdn;
        flush = m2 + N1 + N2;
        cfg_m1 = W'(m1); cfg_m2 = W'(m2); cfg_m3 = W'(m3); cfg_base_c = AW'(base);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        a_cyc = cyc;
        chk("load_cfg_ready", 32'(cfg_ready), 32'(0));
        chk("load_busy", 32'(busy), 32'(1));
        chk("load_eng_rst", 32'(eng_rst), 32'(1));
        chk("load_aborted", 32'(aborted), 32'(0));
        chk("eng_m2", 32'(eng_m2), 32'(m2));
        chk("eng_m1dn1", 32'(eng_m1dn1), 32'(rdn));
        chk("eng_m3dn2", 32'(eng_m3dn2), 32'(cdn));
        chk("eng_tiles", 32'(eng_m1xm3dn1xn2), 32'(tiles));
        tick();
        chk("run_eng_rst", 32'(eng_rst), 32'(0));
        for (int k = 0; k < tiles; k++) begin
            repeat ($urandom_range(gap_lo, gap_hi)) tick();
            p = cyc;
            if (k > 0) expect_tile(p + 1, k - 1, cdn, base);
            if (k == tiles - 1) begin
                expect_tile(p + flush, k, cdn, base);
                exp_done[p + flush + 1] = 1;
            end
            tile_start = 1'b1;
            tick();
            tile_start = 1'b0;
            if (k == abort_k) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_aborted", 32'(aborted), 32'(1));
                chk("abort_eng_rst", 32'(eng_rst), 32'(1));
                chk("abort_busy", 32'(busy), 32'(0));
                tile_start = 1'b1;
                tick();
                tile_start = 1'b0;
                repeat (flush + 4) tick();
                chk("abort_sticky", 32'(aborted), 32'(1));
                return;
            end
        end
        repeat (flush + 2) tick();
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("end_eng_rst", 32'(eng_rst), 32'(1));
        chk("end_eng_held", 32'(eng_m1dn1), 32'(rdn));
`ifdef MATMUL_SEQ_PERF_EN
        chk("perf_cycles", perf_at_done, 32'(done_cyc - 1 - a_cyc));
`else
        chk("perf_zero", perf_cycles, 32'(0));
`endif
    endtask

    task automatic try_bad(input int m1, input int m2, input int m3);
        cfg_m1 = W'(m1); cfg_m2 = W'(m2); cfg_m3 = W'(m3);
        cfg_valid = 1'b1;
        exp_err[cyc + 1] = 1;
        tick();
        cfg_valid = 1'b0;
        chk("bad_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("bad_busy", 32'(busy), 32'(0));
        chk("bad_eng_rst", 32'(eng_rst), 32'(1));
    endtask

    initial begin
        int m1, m2, m3;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst_eng_rst", 32'(eng_rst), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_commit", 32'(tile_commit), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_job_err", 32'(job_err), 32'(0));
        chk("rst_aborted", 32'(aborted), 32'(0));
        chk("rst_eng_m2", 32'(eng_m2), 32'(0));
        chk("rst_tile_addr", 32'(tile_addr), 32'(0));
        chk("rst_perf", perf_cycles, 32'(0));
        rst = 1'b0;
        tick();

        run_job(8, 6, 8, 'h10, 5, 5, -1);
        try_bad(6, 6, 8);
        try_bad(8, 1, 8);
        try_bad(8, 6, 0);
        tick();
        run_job(4, 2, 4, 0, 2, 2, -1);
        run_job(8, 6, 8, 'h10, 5, 5, 1);
        run_job(8, 3, 8, 'hFFE, 0, 3, -1);
        try_bad(1024, 2, 1024);

        for (int i = 0; i < 8; i++) begin
            m1 = $urandom_range(0, 12);
            m2 = $urandom_range(0, 4);
            m3 = $urandom_range(0, 12);
            if (legal(m1, m2, m3)) run_job(m1, m2, m3, $urandom_range(0, 4095), 0, 3, -1);
            else try_bad(m1, m2, m3);
        end

        // Largest tile count that still fits, then cancelled while in LOAD
        cfg_m1 = W'(1024); cfg_m2 = W'(2); cfg_m3 = W'(1020);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("big_busy", 32'(busy), 32'(1));
        chk("big_tiles", 32'(eng_m1xm3dn1xn2), 32'(65280));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("load_abort_busy", 32'(busy), 32'(0));
        chk("load_abort_flag", 32'(aborted), 32'(1));
        chk("load_abort_eng_rst", 32'(eng_rst), 32'(1));

        // Async reset between edges while flushing a single-tile job
        cfg_m1 = W'(4); cfg_m2 = W'(5); cfg_m3 = W'(4); cfg_base_c = AW'(7);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tile_start = 1'b1;
        tick();
        tile_start = 1'b0;
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_eng_rst", 32'(eng_rst), 32'(1));
        chk("arst_eng_m2", 32'(eng_m2), 32'(0));
        chk("arst_eng_tiles", 32'(eng_m1xm3dn1xn2), 32'(0));
        chk("arst_aborted", 32'(aborted), 32'(0));
        chk("arst_perf", perf_cycles, 32'(0));
        #1 rst = 1'b0;
        repeat (16) tick();
        chk("post_arst_ready", 32'(cfg_ready), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
